// File: rtl/nco_pkg.sv
// Shared NCO constants and the quarter-wave magnitude generator used by the ROM and the bench.
package nco_pkg;

  localparam int unsigned NCO_PHASE_W = 24;
  localparam int unsigned NCO_ADDR_W  = 8;
  localparam int unsigned NCO_OUT_W   = 8;

  localparam logic [1:0] QUAD_0 = 2'd0;
  localparam logic [1:0] QUAD_1 = 2'd1;
  localparam logic [1:0] QUAD_2 = 2'd2;
  localparam logic [1:0] QUAD_3 = 2'd3;

  localparam int unsigned FIX_FRAC = 28;
  localparam longint      PI_FIX   = 64'sd843314857;  // pi in Q28

  // round((2^(out_w-1)-1) * sin(pi*(2*idx+1)/2^(addr_w+2))) using a fixed-point Taylor series
  function automatic int nco_mag(input int unsigned idx, input int unsigned addr_w,
                                 input int unsigned out_w);
    longint x;
    longint x2;
    longint term;
    longint acc;
    longint scale;
    x    = (PI_FIX * longint'(2 * idx + 1)) / (longint'(1) <<< (addr_w + 2));
    x2   = (x * x) >>> FIX_FRAC;
    term = x;
    acc  = x;
    for (int k = 1; k <= 7; k++) begin
      term = -((term * x2) >>> FIX_FRAC) / longint'((2 * k) * (2 * k + 1));
      acc  = acc + term;
    end
    scale = (longint'(1) <<< (out_w - 1)) - 1;
    return int'((acc * scale + (longint'(1) <<< (FIX_FRAC - 1))) >>> FIX_FRAC);
  endfunction

endpackage

// File: rtl/sin_quarter_rom.sv
// Dual-read synchronous quarter-wave sine magnitude ROM; both ports see one table.
module sin_quarter_rom
  import nco_pkg::*;
#(
  parameter int unsigned ADDR_W = NCO_ADDR_W,
  parameter int unsigned MAG_W  = NCO_OUT_W - 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  output logic [MAG_W-1:0]  mag_a,
  output logic [MAG_W-1:0]  mag_b
);

  localparam int unsigned DEPTH = 32'(1) << ADDR_W;

  logic [MAG_W-1:0] rom_c [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_tab
    localparam logic [MAG_W-1:0] MAG = MAG_W'(nco_mag(i, ADDR_W, MAG_W + 1));
    assign rom_c[i] = MAG;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag_a <= '0;
      mag_b <= '0;
    end else begin
      mag_a <= rom_c[addr_a];
      mag_b <= rom_c[addr_b];
    end
  end

endmodule

// File: rtl/nco_quad_sincos.sv
// Phase-accumulator NCO producing registered sine/cosine pairs from a folded quarter-wave ROM.
module nco_quad_sincos
  import nco_pkg::*;
#(
  parameter int unsigned PHASE_W   = NCO_PHASE_W,
  parameter int unsigned ADDR_W    = NCO_ADDR_W,
  parameter int unsigned OUT_W     = NCO_OUT_W,
  parameter bit          TWOS_COMP = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [PHASE_W-1:0] freq_word,
  input  logic               freq_load,
  input  logic [PHASE_W-1:0] phase_offset,
  input  logic               phase_clr,
  output logic [OUT_W-1:0]   sin_out,
  output logic [OUT_W-1:0]   cos_out,
  output logic               out_valid
);

  localparam int unsigned P_W   = ADDR_W + 2;
  localparam int unsigned MAG_W = OUT_W - 1;

  logic [PHASE_W-1:0] freq_q;
  logic [PHASE_W-1:0] acc_q;
  logic               vld0_q;

  logic [P_W-1:0]    p_c;
  logic [1:0]        q_sin_c;
  logic [1:0]        q_cos_c;
  logic [ADDR_W-1:0] idx_c;

  logic [ADDR_W-1:0] addr_sin_q, addr_cos_q;
  logic              neg_sin1_q, neg_cos1_q, vld1_q;
  logic              neg_sin2_q, neg_cos2_q, vld2_q;
  logic [MAG_W-1:0]  mag_sin, mag_cos;

  // Frequency register and accumulator; clear beats step, a step always issues a token
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      freq_q <= '0;
      acc_q  <= '0;
      vld0_q <= 1'b0;
    end else begin
      if (freq_load) freq_q <= freq_word;
      if (phase_clr)  acc_q <= '0;
      else if (en)    acc_q <= acc_q + freq_q;
      vld0_q <= en;
    end
  end

  assign p_c     = P_W'((acc_q + phase_offset) >> (PHASE_W - P_W));
  assign q_sin_c = p_c[P_W-1 -: 2];
  assign q_cos_c = q_sin_c + 2'd1;
  assign idx_c   = p_c[ADDR_W-1:0];

  // S1: mirror the index in odd quadrants, negate in the lower half-plane
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_sin_q <= '0;
      addr_cos_q <= '0;
      neg_sin1_q <= 1'b0;
      neg_cos1_q <= 1'b0;
      vld1_q     <= 1'b0;
    end else begin
      addr_sin_q <= ((q_sin_c == QUAD_1) || (q_sin_c == QUAD_3)) ? ~idx_c : idx_c;
      addr_cos_q <= ((q_cos_c == QUAD_1) || (q_cos_c == QUAD_3)) ? ~idx_c : idx_c;
      neg_sin1_q <= (q_sin_c == QUAD_2) || (q_sin_c == QUAD_3);
      neg_cos1_q <= (q_cos_c == QUAD_2) || (q_cos_c == QUAD_3);
      vld1_q     <= vld0_q;
    end
  end

  sin_quarter_rom #(
    .ADDR_W (ADDR_W),
    .MAG_W  (MAG_W)
  ) u_rom (
    .clk    (clk),
    .rst_n  (rst_n),
    .addr_a (addr_sin_q),
    .addr_b (addr_cos_q),
    .mag_a  (mag_sin),
    .mag_b  (mag_cos)
  );

  // S2 side-band alongside the registered ROM reads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_sin2_q <= 1'b0;
      neg_cos2_q <= 1'b0;
      vld2_q     <= 1'b0;
    end else begin
      neg_sin2_q <= neg_sin1_q;
      neg_cos2_q <= neg_cos1_q;
      vld2_q     <= vld1_q;
    end
  end

  // Magnitudes never exceed 2^(OUT_W-1)-1, so the full-scale negative code cannot occur
  function automatic logic [OUT_W-1:0] fmt(input logic neg, input logic [MAG_W-1:0] mag);
    logic [OUT_W-1:0] ext;
    ext = {1'b0, mag};
    if (TWOS_COMP) return neg ? OUT_W'(-ext) : ext;
    return {neg, mag};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sin_out   <= '0;
      cos_out   <= '0;
      out_valid <= 1'b0;
    end else begin
      sin_out   <= fmt(neg_sin2_q, mag_sin);
      cos_out   <= fmt(neg_cos2_q, mag_cos);
      out_valid <= vld2_q;
    end
  end

endmodule
